// File: rtl/cr_huf_comp_st_mqueue_pkg.sv
// rtl/cr_huf_comp_st_mqueue_pkg.sv - shared field widths and types for the symbol-table queue
package cr_huf_comp_st_mqueue_pkg;

  localparam int ST_SYMB_WIDTH  = 6;
  localparam int XTR_SIZE_WIDTH = 13;
  localparam int SEQID_WIDTH    = 8;
  localparam int HLIT_WIDTH     = 5;
  localparam int HDIST_WIDTH    = 5;

  // MIDDLE is deliberately non-zero: an idle/cleared slot is not "all zero" on st_eob
  typedef enum logic [2:0] {
    PASS_THRU = 3'd0,
    MORE      = 3'd1,
    END       = 3'd2,
    MIDDLE    = 3'd7
  } e_pipe_eob;

  typedef enum logic [1:0] {
    COMP_NONE = 2'd0,
    XP10      = 2'd1,
    GZIP      = 2'd2,
    ZLIB      = 2'd3
  } e_comp_mode;

  typedef enum logic [3:0] {
    WIN_DEF = 4'd0,
    WIN_64K = 4'd5
  } e_lz77_win;

  typedef enum logic [1:0] {
    NO_PREFIX  = 2'd0,
    USER_PREFIX = 2'd1
  } e_xp10_prefix;

  typedef struct packed {
    logic [7:0]               extra;
    logic [3:0]               extra_length;
    logic [ST_SYMB_WIDTH-1:0] symbol;
    logic                     val;
  } s_st_sym_buf_intf;

  typedef struct packed {
    e_comp_mode   comp_mode;
    e_lz77_win    lz77_win_size;
    e_xp10_prefix xp10_prefix_mode;
  } s_seq_id_type_intf;

endpackage

// File: rtl/cr_huf_comp_st_mqueue_if.sv
// rtl/cr_huf_comp_st_mqueue_if.sv - builder push side and reader head side of the symbol-table queue
interface cr_huf_comp_st_mqueue_if
  import cr_huf_comp_st_mqueue_pkg::*;
#(
  parameter int DAT_WIDTH              = 10,
  parameter int MAX_SYMBOL_TABLE_DEPTH = 584,
  parameter int PTR_W                  = $clog2(MAX_SYMBOL_TABLE_DEPTH + 1)
);
  logic [MAX_SYMBOL_TABLE_DEPTH-1:0]                    hw_st_val;
  logic [MAX_SYMBOL_TABLE_DEPTH-1:0][ST_SYMB_WIDTH-1:0] hw_st_symbol;
  logic [MAX_SYMBOL_TABLE_DEPTH-1:0][7:0]               hw_st_extra;
  logic [MAX_SYMBOL_TABLE_DEPTH-1:0][3:0]               hw_st_extra_length;
  logic [DAT_WIDTH-1:0]                                 hw_st_last_ptr;
  logic [XTR_SIZE_WIDTH-1:0]                            hw_st_extra_size;
  logic [SEQID_WIDTH-1:0]                               hw_st_seq_id;
  logic [HLIT_WIDTH-1:0]                                hw_st_hlit;
  logic [HDIST_WIDTH-1:0]                               hw_st_hdist;
  logic                                                 hw_st_deflate;
  logic                                                 hw_st_build_error;
  e_pipe_eob                                            hw_st_eob;
  logic                                                 st_ready;

  logic                                                 sa_st_read_done;
  logic                                                 rd_valid;
  s_st_sym_buf_intf                                     sym_buf [MAX_SYMBOL_TABLE_DEPTH];
  logic [PTR_W-1:0]                                     sym_buf_wr_ptr;
  logic [XTR_SIZE_WIDTH-1:0]                            st_extra_size_store;
  logic [HLIT_WIDTH-1:0]                                st_hlit_store;
  logic [HDIST_WIDTH-1:0]                               st_hdist_store;
  logic                                                 st_deflate_store;
  logic                                                 st_build_error;
  logic [SEQID_WIDTH-1:0]                               st_seq_id;
  e_pipe_eob                                            st_eob;
  s_seq_id_type_intf                                    hdr_ht_type_mod;

  modport slave (
    input  hw_st_val, hw_st_symbol, hw_st_extra, hw_st_extra_length, hw_st_last_ptr,
           hw_st_extra_size, hw_st_seq_id, hw_st_hlit, hw_st_hdist, hw_st_deflate,
           hw_st_build_error, hw_st_eob, sa_st_read_done,
    output st_ready, rd_valid, sym_buf, sym_buf_wr_ptr, st_extra_size_store, st_hlit_store,
           st_hdist_store, st_deflate_store, st_build_error, st_seq_id, st_eob, hdr_ht_type_mod
  );

  modport master (
    output hw_st_val, hw_st_symbol, hw_st_extra, hw_st_extra_length, hw_st_last_ptr,
           hw_st_extra_size, hw_st_seq_id, hw_st_hlit, hw_st_hdist, hw_st_deflate,
           hw_st_build_error, hw_st_eob, sa_st_read_done,
    input  st_ready, rd_valid, sym_buf, sym_buf_wr_ptr, st_extra_size_store, st_hlit_store,
           st_hdist_store, st_deflate_store, st_build_error, st_seq_id, st_eob, hdr_ht_type_mod
  );
endinterface

// File: rtl/cr_huf_comp_st_mqueue.sv
// rtl/cr_huf_comp_st_mqueue.sv - NUM_SLOTS-deep FIFO of completed Huffman symbol tables
module cr_huf_comp_st_mqueue
  import cr_huf_comp_st_mqueue_pkg::*;
#(
  parameter int DAT_WIDTH              = 10,
  parameter int MAX_SYMBOL_TABLE_DEPTH = 584,
  parameter int NUM_SLOTS              = 2,
  parameter int CNT_W                  = $clog2(NUM_SLOTS + 1)
) (
  input  logic                    clk_gated,
  input  logic                    rst_n,
  cr_huf_comp_st_mqueue_if.slave  st,
  output logic                    st_overflow,
  output logic                    st_overflow_sticky,
  output logic [CNT_W-1:0]        st_count,
  output logic                    sym_buf_full
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int PTR_W = $clog2(MAX_SYMBOL_TABLE_DEPTH + 1);

  s_st_sym_buf_intf          slot_tab   [NUM_SLOTS][MAX_SYMBOL_TABLE_DEPTH];
  logic [PTR_W-1:0]          slot_ptr   [NUM_SLOTS];
  logic [XTR_SIZE_WIDTH-1:0] slot_xsize [NUM_SLOTS];
  logic [HLIT_WIDTH-1:0]     slot_hlit  [NUM_SLOTS];
  logic [HDIST_WIDTH-1:0]    slot_hdist [NUM_SLOTS];
  logic                      slot_defl  [NUM_SLOTS];
  logic                      slot_berr  [NUM_SLOTS];
  logic [SEQID_WIDTH-1:0]    slot_seq   [NUM_SLOTS];
  e_pipe_eob                 slot_eob   [NUM_SLOTS];
  s_seq_id_type_intf         slot_hdr   [NUM_SLOTS];

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q, sticky_q;
  logic             push, pop, ready, push_ok;

  assign push    = (st.hw_st_eob != MIDDLE);
  assign pop     = st.sa_st_read_done & (count_q != '0);
  assign ready   = (count_q < CNT_W'(NUM_SLOTS)) | pop;
  assign push_ok = push & ready;

  // Pop clears before push writes so that, when full, the freed head slot takes the new table
  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        for (int i = 0; i < MAX_SYMBOL_TABLE_DEPTH; i++) slot_tab[s][i] <= '0;
        slot_ptr[s]   <= '0;
        slot_xsize[s] <= '0;
        slot_hlit[s]  <= '0;
        slot_hdist[s] <= '0;
        slot_defl[s]  <= 1'b0;
        slot_berr[s]  <= 1'b0;
        slot_seq[s]   <= '0;
        slot_eob[s]   <= MIDDLE;
        slot_hdr[s]   <= '0;
      end
      wr_idx     <= '0;
      rd_idx     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      if (pop) begin
        for (int i = 0; i < MAX_SYMBOL_TABLE_DEPTH; i++) slot_tab[rd_idx][i] <= '0;
        slot_ptr[rd_idx]   <= '0;
        slot_xsize[rd_idx] <= '0;
        slot_hlit[rd_idx]  <= '0;
        slot_hdist[rd_idx] <= '0;
        slot_defl[rd_idx]  <= 1'b0;
        slot_berr[rd_idx]  <= 1'b0;
        slot_seq[rd_idx]   <= '0;
        slot_eob[rd_idx]   <= MIDDLE;
        slot_hdr[rd_idx]   <= '0;
        rd_idx             <= rd_idx + IDX_W'(1);
      end
      if (push_ok) begin
        for (int i = 0; i < MAX_SYMBOL_TABLE_DEPTH; i++) begin
          slot_tab[wr_idx][i] <= '{extra:        st.hw_st_extra[i],
                                   extra_length: st.hw_st_extra_length[i],
                                   symbol:       st.hw_st_symbol[i],
                                   val:          st.hw_st_val[i]};
        end
        slot_ptr[wr_idx]   <= PTR_W'(st.hw_st_last_ptr);
        slot_xsize[wr_idx] <= st.hw_st_extra_size;
        slot_hlit[wr_idx]  <= st.hw_st_hlit;
        slot_hdist[wr_idx] <= st.hw_st_hdist;
        slot_defl[wr_idx]  <= st.hw_st_deflate;
        slot_berr[wr_idx]  <= st.hw_st_build_error;
        slot_seq[wr_idx]   <= st.hw_st_seq_id;
        slot_eob[wr_idx]   <= st.hw_st_eob;
        slot_hdr[wr_idx]   <= '{comp_mode:        st.hw_st_deflate ? GZIP : XP10,
                                lz77_win_size:    WIN_64K,
                                xp10_prefix_mode: NO_PREFIX};
        wr_idx             <= wr_idx + IDX_W'(1);
      end
      if (push_ok && !pop) count_q <= count_q + CNT_W'(1);
      else if (pop && !push_ok) count_q <= count_q - CNT_W'(1);
      overflow_q <= push & ~ready;
      sticky_q   <= sticky_q | (push & ~ready);
    end
  end

  assign st.st_ready            = ready;
  assign st.rd_valid            = (count_q != '0);
  assign st.sym_buf             = slot_tab[rd_idx];
  assign st.sym_buf_wr_ptr      = slot_ptr[rd_idx];
  assign st.st_extra_size_store = slot_xsize[rd_idx];
  assign st.st_hlit_store       = slot_hlit[rd_idx];
  assign st.st_hdist_store      = slot_hdist[rd_idx];
  assign st.st_deflate_store    = slot_defl[rd_idx];
  assign st.st_build_error      = slot_berr[rd_idx];
  assign st.st_seq_id           = slot_seq[rd_idx];
  assign st.st_eob              = slot_eob[rd_idx];
  assign st.hdr_ht_type_mod     = slot_hdr[rd_idx];

  assign st_overflow        = overflow_q;
  assign st_overflow_sticky = sticky_q;
  assign st_count           = count_q;
  assign sym_buf_full       = (count_q == CNT_W'(NUM_SLOTS));
endmodule

// File: tb/tb_cr_huf_comp_st_mqueue.sv
// tb/tb_cr_huf_comp_st_mqueue.sv - directed bench for the multi-slot symbol-table queue
module tb_cr_huf_comp_st_mqueue;
  import cr_huf_comp_st_mqueue_pkg::*;

  localparam int DEPTH = 584;
  localparam int SLOTS = 2;
  localparam int CW    = $clog2(SLOTS + 1);

  logic          clk_gated = 1'b0;
  logic          rst_n;
  logic          st_overflow, st_overflow_sticky, sym_buf_full;
  logic [CW-1:0] st_count;
  int            errors = 0;
  int            checks = 0;

  cr_huf_comp_st_mqueue_if #(.DAT_WIDTH(10), .MAX_SYMBOL_TABLE_DEPTH(DEPTH)) st_if ();

  cr_huf_comp_st_mqueue #(
    .DAT_WIDTH(10), .MAX_SYMBOL_TABLE_DEPTH(DEPTH), .NUM_SLOTS(SLOTS)
  ) dut (
    .clk_gated          (clk_gated),
    .rst_n              (rst_n),
    .st                 (st_if.slave),
    .st_overflow        (st_overflow),
    .st_overflow_sticky (st_overflow_sticky),
    .st_count           (st_count),
    .sym_buf_full       (sym_buf_full)
  );

  always #5 clk_gated = ~clk_gated;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_gated);
    #1;
  endtask

  function automatic s_st_sym_buf_intf entry(input int seq, input int i);
    s_st_sym_buf_intf e;
    e.val          = 1'((i + seq) & 1);
    e.symbol       = ST_SYMB_WIDTH'((i * 3 + seq) % 64);
    e.extra        = 8'((i + seq * 7) & 255);
    e.extra_length = 4'((i + seq) & 15);
    return e;
  endfunction

  task automatic load(input int seq, input logic defl, input int ptr);
    s_st_sym_buf_intf e;
    for (int i = 0; i < DEPTH; i++) begin
      e = entry(seq, i);
      st_if.hw_st_val[i]          = e.val;
      st_if.hw_st_symbol[i]       = e.symbol;
      st_if.hw_st_extra[i]        = e.extra;
      st_if.hw_st_extra_length[i] = e.extra_length;
    end
    st_if.hw_st_seq_id      = SEQID_WIDTH'(seq);
    st_if.hw_st_deflate     = defl;
    st_if.hw_st_last_ptr    = 10'(ptr);
    st_if.hw_st_extra_size  = XTR_SIZE_WIDTH'(seq + 100);
    st_if.hw_st_hlit        = HLIT_WIDTH'(seq + 1);
    st_if.hw_st_hdist       = HDIST_WIDTH'(seq + 2);
    st_if.hw_st_build_error = 1'b0;
    st_if.hw_st_eob         = END;
  endtask

  task automatic chk_head(input string tag, input int seq, input logic defl);
    chk({tag, "_seq"}, st_if.st_seq_id, seq);
    chk({tag, "_comp"}, st_if.hdr_ht_type_mod.comp_mode, defl ? GZIP : XP10);
    chk({tag, "_hlit"}, st_if.st_hlit_store, seq + 1);
    chk({tag, "_e0"}, st_if.sym_buf[0], entry(seq, 0));
    chk({tag, "_e583"}, st_if.sym_buf[583], entry(seq, 583));
  endtask

  task automatic chk_zero(input string tag);
    logic any;
    any = 1'b0;
    for (int i = 0; i < DEPTH; i++) any = any | (|st_if.sym_buf[i]);
    chk(tag, any, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    load(0, 1'b0, 0);
    st_if.hw_st_eob       = MIDDLE;
    st_if.sa_st_read_done = 1'b0;
    step();
    step();
    chk("rst_count", st_count, 0);
    chk("rst_rd_valid", st_if.rd_valid, 0);
    chk("rst_eob", st_if.st_eob, MIDDLE);
    chk("rst_ready", st_if.st_ready, 1);
    chk("rst_hdr", st_if.hdr_ht_type_mod, 0);
    chk("rst_full", sym_buf_full, 0);
    chk_zero("rst_symbuf_zero");
    rst_n = 1'b1;
    step();

    // single deflate table in and out
    load(5, 1'b1, 286);
    step();
    st_if.hw_st_eob = MIDDLE;
    chk("p1_rd_valid", st_if.rd_valid, 1);
    chk("p1_ptr", st_if.sym_buf_wr_ptr, 286);
    chk("p1_eob", st_if.st_eob, END);
    chk("p1_win", st_if.hdr_ht_type_mod.lz77_win_size, WIN_64K);
    chk("p1_count", st_count, 1);
    chk_head("p1", 5, 1'b1);
    st_if.sa_st_read_done = 1'b1;
    step();
    st_if.sa_st_read_done = 1'b0;
    chk("p1pop_rd_valid", st_if.rd_valid, 0);
    chk("p1pop_eob", st_if.st_eob, MIDDLE);
    chk("p1pop_count", st_count, 0);
    chk_zero("p1pop_symbuf_zero");

    // fill, then overflow
    load(1, 1'b0, 10);
    step();
    load(2, 1'b1, 20);
    step();
    st_if.hw_st_eob = MIDDLE;
    chk("full_count", st_count, 2);
    chk("full_flag", sym_buf_full, 1);
    chk("full_ready", st_if.st_ready, 0);
    chk_head("full", 1, 1'b0);
    load(3, 1'b0, 30);
    step();
    st_if.hw_st_eob = MIDDLE;
    chk("ovf_pulse", st_overflow, 1);
    chk("ovf_sticky", st_overflow_sticky, 1);
    chk("ovf_count", st_count, 2);
    step();
    chk("ovf_pulse_gone", st_overflow, 0);
    chk("ovf_sticky_hold", st_overflow_sticky, 1);
    st_if.sa_st_read_done = 1'b1;
    step();
    st_if.sa_st_read_done = 1'b0;
    chk("ovfpop_count", st_count, 1);
    chk_head("ovfpop", 2, 1'b1);

    // full with simultaneous push and pop
    load(4, 1'b0, 40);
    step();
    chk("sim_prefull", st_count, 2);
    load(6, 1'b1, 60);
    st_if.sa_st_read_done = 1'b1;
    #1;
    chk("sim_ready", st_if.st_ready, 1);
    step();
    st_if.hw_st_eob       = MIDDLE;
    st_if.sa_st_read_done = 1'b0;
    chk("sim_count", st_count, 2);
    chk("sim_no_ovf", st_overflow, 0);
    chk_head("sim", 4, 1'b0);
    st_if.sa_st_read_done = 1'b1;
    step();
    chk_head("sim2", 6, 1'b1);
    step();
    st_if.sa_st_read_done = 1'b0;
    chk("sim_empty", st_count, 0);

    // alternating push/pop across the index wrap
    for (int k = 0; k < 8; k++) begin
      load(10 + k, 1'(k & 1), 100 + k);
      step();
      st_if.hw_st_eob = MIDDLE;
      chk("alt_seq", st_if.st_seq_id, 10 + k);
      chk("alt_count", st_count, 1);
      st_if.sa_st_read_done = 1'b1;
      step();
      st_if.sa_st_read_done = 1'b0;
      chk("alt_ovf", st_overflow, 0);
    end
    chk("alt_end_count", st_count, 0);

    // pop while empty
    st_if.sa_st_read_done = 1'b1;
    step();
    st_if.sa_st_read_done = 1'b0;
    chk("epop_count", st_count, 0);
    chk("epop_rd_valid", st_if.rd_valid, 0);
    load(20, 1'b1, 200);
    step();
    st_if.hw_st_eob = MIDDLE;
    chk("epop_push_count", st_count, 1);
    chk_head("epop_push", 20, 1'b1);

    // asynchronous reset with two slots occupied
    load(21, 1'b0, 210);
    step();
    st_if.hw_st_eob = MIDDLE;
    chk("prerst_count", st_count, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_count", st_count, 0);
    chk("arst_rd_valid", st_if.rd_valid, 0);
    chk("arst_sticky", st_overflow_sticky, 0);
    chk("arst_eob", st_if.st_eob, MIDDLE);
    chk("arst_seq", st_if.st_seq_id, 0);
    chk_zero("arst_symbuf_zero");
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_count", st_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
